// File: rtl/uart_tx_arb_pkg.sv
// Shared types and limits for the UART transmit arbiter.
package uart_tx_arb_pkg;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} arb_state_t;
  localparam int MAX_REQ = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request bit scanning ptr, ptr+1, ... modulo N_REQ.
module rr_pick
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);
  logic [IDX_W:0]   sum  [N_REQ];
  logic [IDX_W-1:0] cand [N_REQ];
  logic [N_REQ-1:0] rot;

  // cand[gi] is the requester examined at rotation offset gi.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign sum[gi]  = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum[gi] >= (IDX_W+1)'(N_REQ)) ?
                        IDX_W'(sum[gi] - (IDX_W+1)'(N_REQ)) : sum[gi][IDX_W-1:0];
      assign rot[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        any = 1'b1;
        idx = cand[k];
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-atomic round-robin arbiter sharing one UART transmitter among N_REQ byte streams.
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               output_busy,
  output logic               output_en,
  output logic [7:0]         output_data,
  output logic [IDX_W-1:0]   grant_id,
  output logic               active
);
  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] grant_reg, grant_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic             last_sent_reg, last_sent_next;
  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req (req_valid),
    .ptr (ptr_reg),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      ptr_reg       <= '0;
      last_sent_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      ptr_reg       <= ptr_next;
      last_sent_reg <= last_sent_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    ptr_next       = ptr_reg;
    last_sent_next = last_sent_reg;
    req_ready      = '0;
    output_en      = 1'b0;
    output_data    = 8'h00;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          grant_next = pick_idx;
          state_next = SEND;
        end
      end
      SEND: begin
        // A stalled grantee holds the line indefinitely; no timeout.
        if (req_valid[grant_reg] && !output_busy) begin
          output_en            = 1'b1;
          output_data          = req_data[{grant_reg, 3'b000} +: 8];
          req_ready[grant_reg] = 1'b1;
          last_sent_next       = req_last[grant_reg];
          state_next           = WAIT;
        end
      end
      WAIT: begin
        if (!output_busy) begin
          if (last_sent_reg) begin
            state_next = IDLE;
            ptr_next   = (grant_reg == IDX_W'(N_REQ - 1)) ? '0 : grant_reg + IDX_W'(1);
          end else begin
            state_next = SEND;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign grant_id = grant_reg;
  assign active   = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed + randomized bench for uart_tx_arbiter; message-level reference model for N_REQ=2, directed N_REQ=4 wrap check.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  a_valid, a_last, a_ready;
  logic [15:0] a_data;
  logic        a_busy, a_en, a_active;
  logic [7:0]  a_out;
  logic [0:0]  a_gid;
  logic [3:0]  b_valid, b_last, b_ready;
  logic [31:0] b_data;
  logic        b_busy, b_en, b_active;
  logic [7:0]  b_out;
  logic [1:0]  b_gid;

  uart_tx_arbiter #(.N_REQ(2)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_data(a_data), .req_last(a_last),
    .req_ready(a_ready), .output_busy(a_busy), .output_en(a_en), .output_data(a_out),
    .grant_id(a_gid), .active(a_active));

  uart_tx_arbiter #(.N_REQ(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
    .req_ready(b_ready), .output_busy(b_busy), .output_en(b_en), .output_data(b_out),
    .grant_id(b_gid), .active(b_active));

  int n_cmp = 0, n_err = 0;
  // Per-requester byte queues (stimulus source and model contents).
  logic [7:0] q_d [2][512];
  bit         q_l [2][512];
  int         head [2], tail [2];
  bit         hold [2];
  bit         stuck, rst_nx, gap_on;
  int         bcnt, blen_lo, blen_hi;
  logic [3:0] b_valid_nx, b_last_nx;
  logic [31:0] b_data_nx;
  // Message-level model state.
  bit m_locked;
  int m_owner, m_ptr, cyc_no, prev_en, prev_len, en_cnt;
  int grants [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input bit last);
    q_d[r][tail[r]] = d;
    q_l[r][tail[r]] = last;
    tail[r]++;
  endtask

  task automatic push_msg(input int r, input int len);
    for (int k = 0; k < len; k++) push_byte(r, 8'($urandom), k == len - 1);
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, check against the model.
  task automatic cyc();
    logic [1:0] vdrv;
    @(negedge clk);
    rst     = rst_nx;
    a_busy  = stuck || (bcnt > 0);
    b_valid = b_valid_nx;
    b_data  = b_data_nx;
    b_last  = b_last_nx;
    for (int r = 0; r < 2; r++) begin
      vdrv[r]          = (head[r] < tail[r]) && !hold[r];
      a_valid[r]       = vdrv[r];
      a_data[8*r +: 8] = vdrv[r] ? q_d[r][head[r]] : 8'h00;
      a_last[r]        = vdrv[r] && q_l[r][head[r]];
    end
    #1;
    if (a_en) begin
      int exp_gap;
      if (!m_locked) begin
        for (int k = 1; k >= 0; k--)
          if (vdrv[(m_ptr + k) % 2]) m_owner = (m_ptr + k) % 2;
        m_locked = 1'b1;
        exp_gap  = prev_len + 3;
      end else begin
        exp_gap  = prev_len + 2;
      end
      if (gap_on && prev_en >= 0) chk("en_gap", cyc_no - prev_en, exp_gap);
      chk("grant_id", a_gid, m_owner);
      chk("ready_onehot", a_ready, 1 << m_owner);
      chk("data", a_out, q_d[m_owner][head[m_owner]]);
      if (q_l[m_owner][head[m_owner]]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % 2;
      end
      head[m_owner]++;
      grants[m_owner]++;
      en_cnt++;
      prev_en  = cyc_no;
      prev_len = $urandom_range(blen_hi, blen_lo);
      bcnt     = prev_len;
    end else begin
      chk("idle_data", a_out, 0);
      chk("idle_ready", a_ready, 0);
      if (bcnt > 0) bcnt--;
    end
    if (rst) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      prev_en  = -1;
    end
    cyc_no++;
  endtask

  task automatic wait_en(input int lim, input string tag);
    int k = 0;
    do begin
      cyc();
      k++;
    end while (!a_en && k < lim);
    chk(tag, a_en, 1);
  endtask

  task automatic drain(input int lim);
    int k = 0;
    do begin
      cyc();
      k++;
    end while ((head[0] < tail[0] || head[1] < tail[1] || a_active) && k < lim);
    chk("drain_done", a_active, 0);
  endtask

  initial begin
    int k, base;
    rst = 1'b1; rst_nx = 1'b1; stuck = 1'b0; gap_on = 1'b0; bcnt = 0;
    a_valid = '0; a_data = '0; a_last = '0; a_busy = 1'b0;
    b_valid = '0; b_data = '0; b_last = '0; b_busy = 1'b0;
    b_valid_nx = '0; b_data_nx = '0; b_last_nx = '0;
    head = '{0, 0}; tail = '{0, 0}; hold = '{0, 0}; grants = '{0, 0};
    m_locked = 1'b0; m_owner = 0; m_ptr = 0; cyc_no = 0; prev_en = -1; prev_len = 0; en_cnt = 0;
    blen_lo = 3; blen_hi = 3;

    // Reset state.
    repeat (3) cyc();
    chk("rst_en", a_en, 0); chk("rst_data", a_out, 0); chk("rst_ready", a_ready, 0);
    chk("rst_gid", a_gid, 0); chk("rst_active", a_active, 0);
    rst_nx = 1'b0;

    // "OK" from requester 0, busy 3 cycles after each pulse.
    gap_on = 1'b1;
    push_byte(0, 8'h4F, 1'b0);
    push_byte(0, 8'h4B, 1'b1);
    cyc();
    chk("lat_idle_en", a_en, 0);
    chk("lat_idle_active", a_active, 0);
    cyc();
    chk("lat_first_en", a_en, 1);
    wait_en(20, "ok_second_en");
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("ok_active_wait", a_active, 1);
    end
    cyc();
    chk("ok_active_fall", a_active, 0);

    // Both requesters streaming 1-byte messages from reset: strict alternation.
    rst_nx = 1'b1; cyc(); rst_nx = 1'b0;
    blen_lo = 1; blen_hi = 3; grants = '{0, 0};
    for (int i = 0; i < 10; i++) begin
      push_msg(0, 1);
      push_msg(1, 1);
    end
    base = en_cnt; k = 0;
    while (en_cnt - base < 20 && k < 400) begin
      cyc();
      k++;
      if (a_en) chk("alternate", a_gid, (en_cnt - base - 1) % 2);
    end
    chk("fair_req0", grants[0], 10);
    chk("fair_req1", grants[1], 10);

    // Requester 0 drops valid mid-message while requester 1 waits.
    gap_on = 1'b0; blen_lo = 1; blen_hi = 1;
    push_msg(0, 3);
    push_msg(1, 1);
    wait_en(20, "hold_first_en");
    chk("hold_owner", a_gid, 0);
    hold[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("hold_no_en", a_en, 0);
      chk("hold_ready1", a_ready[1], 0);
      chk("hold_active", a_active, 1);
    end
    hold[0] = 1'b0;
    wait_en(20, "hold_resume_en");
    chk("hold_resume_gid", a_gid, 0);
    drain(200);

    // Busy stuck high while a byte waits in SEND.
    stuck = 1'b1;
    push_msg(1, 1);
    for (int i = 0; i < 50; i++) begin
      cyc();
      chk("stuck_no_en", a_en, 0);
    end
    stuck = 1'b0;
    cyc();
    chk("unstick_en", a_en, 1);
    drain(100);

    // Reset in WAIT during a 3-byte message; arbitration restarts at requester 0.
    push_msg(0, 1);
    drain(100);
    push_msg(1, 3);
    wait_en(20, "rstwait_en");
    chk("rstwait_gid", a_gid, 1);
    rst_nx = 1'b1; cyc(); rst_nx = 1'b0;
    push_msg(0, 1);
    cyc();
    chk("post_rst_en", a_en, 0); chk("post_rst_data", a_out, 0);
    chk("post_rst_ready", a_ready, 0); chk("post_rst_gid", a_gid, 0);
    chk("post_rst_active", a_active, 0);
    wait_en(20, "restart_en");
    chk("restart_gid", a_gid, 0);
    drain(200);

    // Randomized messages with random busy lengths.
    gap_on = 1'b1; prev_en = -1; blen_lo = 1; blen_hi = 4;
    for (int i = 0; i < 14; i++) push_msg(int'($urandom_range(1, 0)), int'($urandom_range(4, 1)));
    drain(2000);

    // N_REQ=4: requester 3 alone, then requester 0 alone after ptr wraps.
    rst_nx = 1'b1; cyc(); rst_nx = 1'b0;
    b_valid_nx = 4'b1000; b_data_nx = 32'hA300_0000; b_last_nx = 4'b1000;
    k = 0;
    do begin cyc(); k++; end while (!b_en && k < 10);
    chk("b3_latency", k, 2);
    chk("b3_gid", b_gid, 3); chk("b3_data", b_out, 8'hA3); chk("b3_ready", b_ready, 4'b1000);
    b_valid_nx = '0; b_data_nx = '0; b_last_nx = '0;
    k = 0;
    do begin cyc(); k++; end while (b_active && k < 10);
    chk("b3_idle", b_active, 0);
    b_valid_nx = 4'b0001; b_data_nx = 32'h0000_00A0; b_last_nx = 4'b0001;
    k = 0;
    do begin cyc(); k++; end while (!b_en && k < 10);
    chk("b0_latency", k, 2);
    chk("b0_gid", b_gid, 0); chk("b0_data", b_out, 8'hA0); chk("b0_ready", b_ready, 4'b0001);
    b_valid_nx = '0; b_data_nx = '0; b_last_nx = '0;
    repeat (3) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
